// File: rtl/regfile_ctrl_pkg.sv
// Shared types and default sizes for the register-file write-port controller.
//   rf_state_e : sequencer state (INIT = zeroing sweep, RUN = normal arbitration)
//   *_DEF      : default register count, index width and data width
package regfile_ctrl_pkg;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_e;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for registers owned by in-flight long operations.
//   clk, rst          : clock, async active-high reset (clears all bits)
//   set_en, set_idx   : mark register set_idx busy
//   clr_en, clr_idx   : release register clr_idx
//   busy              : bit i = register i busy; bit 0 is constant 0
// A set and a clear of the same register in one cycle leaves it busy: the
// set belongs to a newly issued op that now owns the register.
module rf_scoreboard
  import regfile_ctrl_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [AW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_idx,
  output logic [NREG-1:0] busy
);

  // x0 has no storage; it can never be owned.
  logic [NREG-1:1] busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (set_en && set_idx == AW'(i))
          busy_q[i] <= 1'b1;
        else if (clr_en && clr_idx == AW'(i))
          busy_q[i] <= 1'b0;
      end
    end
  end

  assign busy = {busy_q, 1'b0};

endmodule

// File: rtl/regfile_ctrl.sv
// Sequencer and write-port arbiter in front of the register file.
//   clk, rst                        : clock, async active-high reset
//   core_we/core_rd/core_wdata      : core writeback (top priority, no backpressure)
//   lu_valid/lu_rd/lu_wdata/lu_ready: multi-cycle unit result, valid/ready
//   claim_en/claim_rd               : long op issued, destination becomes busy
//   busy                            : per-register busy scoreboard
//   init_done                       : high once the zeroing sweep is finished
//   write_en/write_reg/write_data   : register file write port
// After reset the port zeroes x1..x(NREG-1), one register per cycle, then
// arbitrates between the core and the multi-cycle unit. x0 is never written.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int NREG       = NREG_DEF,
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int INIT_CLEAR = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            core_we,
  input  logic [AW-1:0]   core_rd,
  input  logic [DW-1:0]   core_wdata,
  input  logic            lu_valid,
  input  logic [AW-1:0]   lu_rd,
  input  logic [DW-1:0]   lu_wdata,
  output logic            lu_ready,
  input  logic            claim_en,
  input  logic [AW-1:0]   claim_rd,
  output logic [NREG-1:0] busy,
  output logic            init_done,
  output logic            write_en,
  output logic [AW-1:0]   write_reg,
  output logic [DW-1:0]   write_data
);

  localparam rf_state_e     RST_STATE = (INIT_CLEAR != 0) ? INIT : RUN;
  localparam logic [AW-1:0] LAST_REG  = AW'(NREG - 1);

  rf_state_e     state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          we_c, rdy_c, sb_set, sb_clr;
  logic [AW-1:0] reg_c;
  logic [DW-1:0] data_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_STATE;
      cnt   <= AW'(1);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    we_c      = 1'b0;
    reg_c     = '0;
    data_c    = '0;
    rdy_c     = 1'b0;
    sb_set    = 1'b0;
    sb_clr    = 1'b0;
    case (state)
      // Core writes and claims arriving during the sweep are dropped.
      INIT: begin
        we_c    = 1'b1;
        reg_c   = cnt;
        cnt_nxt = cnt + AW'(1);
        if (cnt == LAST_REG)
          state_nxt = RUN;
      end
      RUN: begin
        // A core write to x0 is a no-op and leaves the port to the unit.
        if (core_we && core_rd != '0) begin
          we_c   = 1'b1;
          reg_c  = core_rd;
          data_c = core_wdata;
        end else begin
          rdy_c = 1'b1;
          // A unit result for x0 still completes its handshake, unwritten.
          if (lu_valid && lu_rd != '0) begin
            we_c   = 1'b1;
            reg_c  = lu_rd;
            data_c = lu_wdata;
          end
        end
        sb_set = claim_en && (claim_rd != '0);
        sb_clr = lu_valid && rdy_c;
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  // Reset masks the port immediately, not from the next edge. The gating
  // stays on the outputs so reset never enters a flop's data path.
  assign write_en   = we_c & ~rst;
  assign write_reg  = rst ? '0 : reg_c;
  assign write_data = rst ? '0 : data_c;
  assign lu_ready   = rdy_c & ~rst;
  assign init_done  = (state == RUN);

  rf_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (sb_set),
    .set_idx (claim_rd),
    .clr_en  (sb_clr),
    .clr_idx (lu_rd),
    .busy    (busy)
  );

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
- Sequencer and write-port arbiter in front of the 32x32 register file.
- After reset, sweeps x1..x31 to zero through the regfile's single write port.
- In normal operation, shares that write port between the core writeback path (fixed priority, no backpressure) and a multi-cycle unit (load/divide, valid/ready).
- Keeps a per-register busy scoreboard so the core can stall on registers owned by in-flight long operations.

Parameters:
- NREG, 32, number of architectural registers (x0 hard-wired zero)
- AW, 5, register index width, equals clog2(NREG)
- DW, 32, data width
- INIT_CLEAR, 1, 1 = run zeroing sweep after reset; 0 = enter RUN directly

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- core_we  in  1  core writeback request, single cycle
- core_rd  in  AW  core destination register
- core_wdata  in  DW  core writeback data
- lu_valid  in  1  multi-cycle unit has a result
- lu_rd  in  AW  multi-cycle unit destination
- lu_wdata  in  DW  multi-cycle unit data
- lu_ready  out  1  multi-cycle result accepted this cycle when lu_valid=1
- claim_en  in  1  core issues a long op this cycle
- claim_rd  in  AW  destination of issued long op
- busy  out  NREG  bit i = register i awaiting multi-cycle result
- init_done  out  1  high once RUN entered
- write_en  out  1  to regfile write enable
- write_reg  out  AW  to regfile write address
- write_data  out  DW  to regfile write data

Behaviour:
- Registered state: fsm state {INIT, RUN}, init counter (AW bits), busy vector. Write-port outputs and lu_ready are combinational from state and inputs.
- While rst=1: state = INIT (INIT_CLEAR=1) or RUN (INIT_CLEAR=0); counter = 1; busy = 0; init_done = 0 (or 1 if INIT_CLEAR=0); write_en = 0; lu_ready = 0.
- INIT:
  - write_en = 1, write_reg = counter, write_data = 0, lu_ready = 0.
  - core_we and claim_en are ignored (protocol error; dropped, no state change).
  - Counter increments each cycle.
  - On the cycle writing NREG-1: next state RUN, init_done = 1 from the following cycle.
  - The sweep takes exactly NREG-1 = 31 cycles after rst deasserts. x0 is never written.
- RUN, arbitration per cycle:
  - core_we=1 and core_rd!=0: grant core. write_en=1, write_reg=core_rd, write_data=core_wdata, lu_ready=0.
  - Otherwise lu_ready = 1.
    - If lu_valid=1 and lu_rd!=0: write_en=1, write_reg=lu_rd, write_data=lu_wdata.
    - If lu_valid=1 and lu_rd=0: accepted and handshake completes, but write_en=0.
  - core_we=1 with core_rd=0 is a no-write: the port is free for lu.
  - Nothing granted: write_en=0; write_reg and write_data are don't-care (drive 0).
  - lu must hold lu_valid/lu_rd/lu_wdata stable until lu_ready=1. A core stream may starve lu; that is accepted by design.
- Scoreboard (RUN only):
  - claim_en=1 and claim_rd!=0: busy[claim_rd] <= 1.
  - lu handshake (lu_valid & lu_ready): busy[lu_rd] <= 0.
  - Same register claimed and cleared in the same cycle: set wins, busy stays 1 (new owner).
  - Claim of an already-busy register: illegal; busy remains 1, no counting.
  - Core write to a busy register: performed; busy unchanged.
  - busy[0] is constant 0.
- Reset asserted mid-INIT or mid-RUN: immediate return to reset values; the sweep restarts from x1 after release; pending lu results are lost.

Decomposition:
- Package regfile_ctrl_pkg: state enum (INIT, RUN), constants NREG_DEF=32, AW_DEF=5, DW_DEF=32.
- One sub-module, rf_scoreboard: busy vector with set/clear inputs and set-wins priority.
- The arbiter and FSM stay in regfile_ctrl.

Test Plan:
- Reset sweep: rst pulse, INIT_CLEAR=1 -> write_en=1 with write_reg 1,2,...,31 on consecutive cycles, write_data=0; init_done=1 on cycle 32; write_reg never 0.
- Priority: RUN, core_we=1 rd=10 data=12983 and lu_valid=1 rd=30 data=324 -> cycle 1 writes x10=12983 with lu_ready=0; cycle 2 (core_we=0) writes x30=324 with lu_ready=1.
- x0 handling: core_we=1 rd=0 data=500 with lu_valid=1 rd=5 data=7 -> write_en=1 reg=5 data=7, lu_ready=1; lu_valid=1 rd=0 alone -> lu_ready=1, write_en=0.
- Scoreboard: claim_en rd=12 -> busy[12]=1 next cycle; lu handshake rd=12 -> busy[12]=0 next cycle; claim rd=12 and lu accept rd=12 in the same cycle -> busy[12] stays 1.
- Reset mid-sweep: assert rst when write_reg=17 -> write_en=0 and busy=0 immediately; after release the sweep restarts at x1 and takes 31 cycles.
- INIT_CLEAR=0: after reset release -> init_done=1 and lu_ready=1 in the first cycle; core_we rd=3 is written immediately.
